// File: rtl/skew_matrix_loader_if.sv
// skew_matrix_loader_if: write port, stream control and skewed lane outputs of the matrix loader
interface skew_matrix_loader_if #(
   parameter int N    = 4,
   parameter int BITS = 8
);
   logic                     wr_en;
   logic [$clog2(N)-1:0]     wr_row;
   logic [N-1:0][BITS-1:0]   wr_data;
   logic                     wr_ready;
   logic                     start;
   logic                     transpose;
   logic                     busy;
   logic [N-1:0]             out_valid;
   logic [N-1:0][BITS-1:0]   out_data;
   logic                     done;

   modport master (
      output wr_en, wr_row, wr_data, start, transpose,
      input  wr_ready, busy, out_valid, out_data, done
   );

   modport slave (
      input  wr_en, wr_row, wr_data, start, transpose,
      output wr_ready, busy, out_valid, out_data, done
   );
endinterface

// File: rtl/skew_matrix_loader.sv
// skew_matrix_loader: N x N staging buffer streamed as a diagonal wavefront; SKEW_LOADER_DBUF_EN enables double buffering
module skew_matrix_loader #(
   parameter int N    = 4,
   parameter int BITS = 8
) (
   input logic               clk,
   input logic               rst,
   skew_matrix_loader_if.slave bus
);
   localparam int RW = $clog2(N);
   localparam int TW = $clog2(2*N-1);
   localparam int TL = 2*N-2;
`ifdef SKEW_LOADER_DBUF_EN
   localparam int NB = 2;
`else
   localparam int NB = 1;
`endif

   typedef enum logic {IDLE, STREAM} state_t;

   state_t                   state_q;
   logic [TW-1:0]            t_q, t_d;
   logic                     trans_q, trans_d;
   logic                     act_d, accept, we, wb, rb;
   logic                     busy_q, done_q;
   logic [N-1:0]             valid_q, valid_d;
   logic [N-1:0][BITS-1:0]   data_q, data_d;
   logic [N-1:0][BITS-1:0]   mem_q [NB][N];
   logic [N-1:0][BITS-1:0]   mem_d [NB][N];

   assign accept = bus.start && (state_q == IDLE || done_q);

`ifdef SKEW_LOADER_DBUF_EN
   logic bank_q;
   assign bus.wr_ready = 1'b1;
   assign wb = bank_q;
   assign rb = accept ? bank_q : ~bank_q;
`else
   assign bus.wr_ready = !busy_q;
   assign wb = 1'b0;
   assign rb = 1'b0;
`endif

   // a back-to-back start in the done cycle still commits the write that rides with it
   assign we = bus.wr_en && (bus.wr_ready || accept) && 32'(bus.wr_row) < N;

   assign act_d   = accept || (state_q == STREAM && t_q != TW'(TL));
   assign t_d     = accept ? '0 : t_q + 1'b1;
   assign trans_d = accept ? bus.transpose : trans_q;

   // storage next state; outputs read from it so a write with start is streamed immediately
   always_comb begin
      mem_d = mem_q;
      if (we) mem_d[wb][bus.wr_row] = bus.wr_data;
   end

   // lane i carries element k = t-i of its row (or column when transposed)
   always_comb begin
      valid_d = '0;
      data_d  = '0;
      for (int i = 0; i < N; i++) begin
         valid_d[i] = act_d && int'(t_d) >= i && int'(t_d) <= i + N - 1;
         data_d[i]  = !valid_d[i] ? '0 :
                      trans_d ? mem_d[rb][RW'(int'(t_d) - i)][i] : mem_d[rb][i][RW'(int'(t_d) - i)];
      end
   end

   // FSM, stream counter, storage and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         t_q     <= '0;
         trans_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         valid_q <= '0;
         data_q  <= '0;
         mem_q   <= '{default: '0};
`ifdef SKEW_LOADER_DBUF_EN
         bank_q  <= 1'b0;
`endif
      end else begin
         state_q <= act_d ? STREAM : IDLE;
         t_q     <= act_d ? t_d : '0;
         trans_q <= trans_d;
         busy_q  <= act_d;
         done_q  <= act_d && t_d == TW'(TL);
         valid_q <= valid_d;
         data_q  <= data_d;
         mem_q   <= mem_d;
`ifdef SKEW_LOADER_DBUF_EN
         if (accept) bank_q <= ~bank_q;
`endif
      end
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.out_valid = valid_q;
   assign bus.out_data  = data_q;
endmodule

// File: tb/tb_skew_matrix_loader.sv
// tb_skew_matrix_loader: randomized and directed bench with a snapshot-based reference model
module tb_skew_matrix_loader;
   localparam int N  = 4;
   localparam int B  = 8;
   localparam int TL = 2*N-2;
`ifdef SKEW_LOADER_DBUF_EN
   localparam bit DBUF = 1'b1;
`else
   localparam bit DBUF = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   skew_matrix_loader_if #(.N(N), .BITS(B)) bus();
   skew_matrix_loader #(.N(N), .BITS(B)) dut (.clk(clk), .rst(rst), .bus(bus));

   int checks = 0;
   int errors = 0;
   int dcnt = 0;
   int bcnt = 0;

   logic [B-1:0] mm   [2][N][N];
   logic [B-1:0] snap [N][N];
   bit m_act, m_tr;
   int m_t, m_wb;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic m_step();
      bit dn, acc;
      if (rst) begin
         foreach (mm[b, r, c]) mm[b][r][c] = '0;
         m_act = 0; m_t = 0; m_tr = 0; m_wb = 0;
         return;
      end
      dn  = m_act && m_t == TL;
      acc = bus.start && (!m_act || dn);
      if (bus.wr_en && (DBUF || !m_act || acc) && int'(bus.wr_row) < N)
         for (int c = 0; c < N; c++) mm[m_wb][bus.wr_row][c] = bus.wr_data[c];
      if (acc) begin
         foreach (snap[r, c]) snap[r][c] = mm[m_wb][r][c];
         m_tr = bus.transpose;
         if (DBUF) m_wb ^= 1;
         m_act = 1;
         m_t = 0;
      end else if (m_act) begin
         if (dn) m_act = 0;
         else m_t++;
      end
   endtask

   task automatic compare();
      logic [N-1:0] ev;
      logic [N-1:0][B-1:0] ed;
      ev = '0;
      ed = '0;
      for (int i = 0; i < N; i++)
         if (m_act && m_t >= i && m_t <= i + N - 1) begin
            ev[i] = 1'b1;
            ed[i] = m_tr ? snap[m_t-i][i] : snap[i][m_t-i];
         end
      chk("wr_ready", 64'(bus.wr_ready), 64'(DBUF || !m_act));
      chk("busy", 64'(bus.busy), 64'(m_act));
      chk("done", 64'(bus.done), 64'(m_act && m_t == TL));
      chk("out_valid", 64'(bus.out_valid), 64'(ev));
      chk("out_data", 64'(bus.out_data), 64'(ed));
   endtask

   task automatic tick();
      m_step();
      @(posedge clk);
      @(negedge clk);
      compare();
      if (bus.done) dcnt++;
      if (bus.busy) bcnt++;
   endtask

   task automatic idle();
      rst = 0; bus.wr_en = 0; bus.wr_row = '0; bus.wr_data = '0; bus.start = 0; bus.transpose = 0;
   endtask

   task automatic load_matrix();
      for (int r = 0; r < N; r++) begin
         idle();
         bus.wr_en = 1;
         bus.wr_row = 2'(r);
         for (int c = 0; c < N; c++) bus.wr_data[c] = 8'(16*r + c);
         tick();
      end
      idle();
   endtask

   task automatic go(input bit tr);
      idle();
      bus.start = 1;
      bus.transpose = tr;
      tick();
      idle();
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      // reset with write and start toggling
      idle();
      rst = 1; bus.wr_en = 1; bus.wr_row = 2'd1; bus.wr_data = '1; bus.start = 1;
      tick();
      bus.wr_en = 0; bus.start = 1; bus.transpose = 1;
      tick();
      idle();
      chk("rst_busy", 64'(bus.busy), 0);
      chk("rst_valid", 64'(bus.out_valid), 0);
      chk("rst_data", 64'(bus.out_data), 0);
      chk("rst_done", 64'(bus.done), 0);
      chk("rst_wr_ready", 64'(bus.wr_ready), 1);

      // row order wavefront
      load_matrix();
      bcnt = 0;
      go(0);
      ticks(3);
      chk("row_t3_valid", 64'(bus.out_valid), 64'h0f);
      chk("row_t3_l0", 64'(bus.out_data[0]), 64'h03);
      chk("row_t3_l1", 64'(bus.out_data[1]), 64'h12);
      chk("row_t3_l2", 64'(bus.out_data[2]), 64'h21);
      chk("row_t3_l3", 64'(bus.out_data[3]), 64'h30);
      ticks(3);
      chk("row_t6_valid", 64'(bus.out_valid), 64'h08);
      chk("row_t6_l3", 64'(bus.out_data[3]), 64'h33);
      chk("row_t6_done", 64'(bus.done), 1);
      tick();
      chk("row_idle_busy", 64'(bus.busy), 0);
      chk("row_busy_cycles", 64'(bcnt), 7);

      // column order wavefront
      load_matrix();
      go(1);
      chk("col_t0_valid", 64'(bus.out_valid), 64'h01);
      chk("col_t0_l0", 64'(bus.out_data[0]), 64'h00);
      ticks(3);
      chk("col_t3_l0", 64'(bus.out_data[0]), 64'h30);
      chk("col_t3_l1", 64'(bus.out_data[1]), 64'h21);
      chk("col_t3_l2", 64'(bus.out_data[2]), 64'h12);
      chk("col_t3_l3", 64'(bus.out_data[3]), 64'h03);
      ticks(4);

      // back-to-back start in the done cycle, mid-stream start ignored
      load_matrix();
      dcnt = 0;
      go(0);
      tick();
      bus.start = 1;
      tick();
      idle();
      ticks(4);
      chk("b2b_done_cycle", 64'(bus.done), 1);
      go(0);
      chk("b2b_busy", 64'(bus.busy), 1);
      chk("b2b_t0_valid", 64'(bus.out_valid), 64'h01);
      ticks(7);
      chk("b2b_done_count", 64'(dcnt), 2);

      // write during stream
      load_matrix();
      go(0);
      tick();
      bus.wr_en = 1; bus.wr_row = 2'd1; bus.wr_data = '1;
      chk("stream_wr_ready", 64'(bus.wr_ready), 64'(DBUF));
      tick();
      idle();
      ticks(5);
      go(0);
      tick();
      chk("next_l1_valid", 64'(bus.out_valid[1]), 1);
      chk("next_l1_data", 64'(bus.out_data[1]), DBUF ? 64'hff : 64'h10);
      ticks(6);

      // reset mid-stream
      load_matrix();
      go(0);
      ticks(2);
      rst = 1;
      tick();
      idle();
      chk("abort_valid", 64'(bus.out_valid), 0);
      chk("abort_busy", 64'(bus.busy), 0);
      dcnt = 0;
      ticks(8);
      chk("abort_no_done", 64'(dcnt), 0);
      go(0);
      ticks(3);
      chk("zero_t3_valid", 64'(bus.out_valid), 64'h0f);
      chk("zero_t3_data", 64'(bus.out_data), 0);
      ticks(4);

      // randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         rst = ($urandom_range(0, 63) == 0);
         bus.wr_en = $urandom_range(0, 1);
         bus.wr_row = 2'($urandom_range(0, N-1));
         for (int c = 0; c < N; c++) bus.wr_data[c] = 8'($urandom);
         bus.start = ($urandom_range(0, 3) == 0);
         bus.transpose = $urandom_range(0, 1);
         tick();
      end
      idle();
      ticks(8);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
